// File: rtl/fifo_chk_pkg.sv
// Shared constants and helpers for the FIFO flag checker: mismatch bit layout
// and the expected-flag computation from an occupancy count.
package fifo_chk_pkg;

    localparam int unsigned ERR_W = 8;

    localparam int unsigned BIT_DATA      = 0;
    localparam int unsigned BIT_WR_ACK    = 1;
    localparam int unsigned BIT_OVERFLOW  = 2;
    localparam int unsigned BIT_UNDERFLOW = 3;
    localparam int unsigned BIT_FULL      = 4;
    localparam int unsigned BIT_EMPTY     = 5;
    localparam int unsigned BIT_AFULL     = 6;
    localparam int unsigned BIT_AEMPTY    = 7;

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } flags_t;

    function automatic flags_t calc_flags(input int unsigned count, input int unsigned depth);
        flags_t f;
        f.full        = (count == depth);
        f.empty       = (count == 0);
        f.almostfull  = (count == depth - 1);
        f.almostempty = (count == 1);
        return f;
    endfunction

endpackage

// File: rtl/fifo_chk_model.sv
// Shadow reference model of the synchronous FIFO: tracks occupancy, pointers and
// data, and registers the expected response for comparison on the following edge.
module fifo_chk_model
    import fifo_chk_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              exp_wr_ack,
    output logic              exp_overflow,
    output logic              exp_underflow,
    output logic              exp_rd_vld,
    output logic [DATA_W-1:0] exp_data,
    output flags_t            exp_flags
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [OCC_W-1:0]  mcount_q, mcount_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              exp_wr_ack_q, exp_wr_ack_d;
    logic              exp_overflow_q, exp_overflow_d;
    logic              exp_underflow_q, exp_underflow_d;
    logic              exp_rd_vld_q, exp_rd_vld_d;
    logic [DATA_W-1:0] exp_data_q, exp_data_d;

    logic is_full, is_empty, wr_acc, rd_acc;

    always_comb begin
        is_full  = (mcount_q == OCC_W'(DEPTH));
        is_empty = (mcount_q == '0);
        wr_acc   = wr_en && !is_full;
        rd_acc   = rd_en && !is_empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mcount_d = mcount_q;

        // Explicit wrap keeps non-power-of-two depths correct.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   mcount_d = mcount_q + OCC_W'(1);
            2'b01:   mcount_d = mcount_q - OCC_W'(1);
            default: mcount_d = mcount_q;
        endcase

        exp_wr_ack_d    = wr_acc;
        exp_overflow_d  = wr_en && is_full;
        exp_underflow_d = rd_en && is_empty;
        exp_rd_vld_d    = rd_acc;
        exp_data_d      = rd_acc ? mem_q[rd_ptr_q] : exp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcount_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            exp_wr_ack_q    <= 1'b0;
            exp_overflow_q  <= 1'b0;
            exp_underflow_q <= 1'b0;
            exp_rd_vld_q    <= 1'b0;
            exp_data_q      <= '0;
        end else begin
            mcount_q        <= mcount_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            exp_wr_ack_q    <= exp_wr_ack_d;
            exp_overflow_q  <= exp_overflow_d;
            exp_underflow_q <= exp_underflow_d;
            exp_rd_vld_q    <= exp_rd_vld_d;
            exp_data_q      <= exp_data_d;
        end
    end

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign exp_wr_ack    = exp_wr_ack_q;
    assign exp_overflow  = exp_overflow_q;
    assign exp_underflow = exp_underflow_q;
    assign exp_rd_vld    = exp_rd_vld_q;
    assign exp_data      = exp_data_q;
    assign exp_flags     = calc_flags(32'(mcount_q), DEPTH);

endmodule

// File: rtl/fifo_flag_checker.sv
// Passive checker for the synchronous FIFO: compares DUT response with the shadow
// model and keeps sticky error bits, first-failure snapshot and saturating counters.
module fifo_flag_checker
    import fifo_chk_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_out,
    input  logic              wr_ack,
    input  logic              overflow,
    input  logic              underflow,
    input  logic              full,
    input  logic              almostfull,
    input  logic              empty,
    input  logic              almostempty,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_vec,
    output logic [ERR_W-1:0]  first_err,
    output logic [CNT_W-1:0]  correct_count,
    output logic [CNT_W-1:0]  error_count
);

    logic              exp_wr_ack, exp_overflow, exp_underflow, exp_rd_vld;
    logic [DATA_W-1:0] exp_data;
    flags_t            exp_flags;

    fifo_chk_model #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_model (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .exp_wr_ack    (exp_wr_ack),
        .exp_overflow  (exp_overflow),
        .exp_underflow (exp_underflow),
        .exp_rd_vld    (exp_rd_vld),
        .exp_data      (exp_data),
        .exp_flags     (exp_flags)
    );

    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_vec_q, err_vec_d;
    logic [ERR_W-1:0] first_err_q, first_err_d;
    logic [CNT_W-1:0] correct_count_q, correct_count_d;
    logic [CNT_W-1:0] error_count_q, error_count_d;

    logic [ERR_W-1:0] mism;
    logic             cmp_en;

    always_comb begin
        mism                = '0;
        mism[BIT_DATA]      = exp_rd_vld && (data_out != exp_data);
        mism[BIT_WR_ACK]    = (wr_ack      != exp_wr_ack);
        mism[BIT_OVERFLOW]  = (overflow    != exp_overflow);
        mism[BIT_UNDERFLOW] = (underflow   != exp_underflow);
        mism[BIT_FULL]      = (full        != exp_flags.full);
        mism[BIT_EMPTY]     = (empty       != exp_flags.empty);
        mism[BIT_AFULL]     = (almostfull  != exp_flags.almostfull);
        mism[BIT_AEMPTY]    = (almostempty != exp_flags.almostempty);

        cmp_en = chk_en && !rst;

        err_pulse_d     = 1'b0;
        err_vec_d       = err_vec_q;
        first_err_d     = first_err_q;
        correct_count_d = correct_count_q;
        error_count_d   = error_count_q;

        if (cmp_en) begin
            err_pulse_d = (mism != '0);
            err_vec_d   = err_vec_q | mism;
            if (err_vec_q == '0) begin
                first_err_d = mism;
            end
            if (mism == '0) begin
                if (correct_count_q != '1) begin
                    correct_count_d = correct_count_q + CNT_W'(1);
                end
            end else if (error_count_q != '1) begin
                error_count_d = error_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_q     <= 1'b0;
            err_vec_q       <= '0;
            first_err_q     <= '0;
            correct_count_q <= '0;
            error_count_q   <= '0;
        end else begin
            err_pulse_q     <= err_pulse_d;
            err_vec_q       <= err_vec_d;
            first_err_q     <= first_err_d;
            correct_count_q <= correct_count_d;
            error_count_q   <= error_count_d;
        end
    end

    assign err_pulse     = err_pulse_q;
    assign err_vec       = err_vec_q;
    assign first_err     = first_err_q;
    assign correct_count = correct_count_q;
    assign error_count   = error_count_q;

endmodule

// File: tb/tb_fifo_flag_checker.sv
// Directed bench: a behavioural FIFO with fault knobs drives three checker
// instances (DEPTH 8, DEPTH 6, and DEPTH 8 with 3-bit counters for saturation).
module tb_fifo_flag_checker;

    logic        clk;
    logic        rst, chk_en, wr_en, rd_en;
    logic [15:0] data_in;
    logic        stub_ovf, stub_ae, corrupt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural FIFOs, index 0 = depth 8, index 1 = depth 6
    int          f_dep [2] = '{8, 6};
    logic [15:0] f_mem [2][8];
    int          f_cnt [2], f_wp [2], f_rp [2];
    logic [15:0] r_dout [2];
    logic        r_ack [2], r_ovf [2], r_udf [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                f_cnt[k] <= 0; f_wp[k] <= 0; f_rp[k] <= 0;
                r_ack[k] <= 1'b0; r_ovf[k] <= 1'b0; r_udf[k] <= 1'b0; r_dout[k] <= '0;
            end else begin
                automatic bit wa = wr_en && (f_cnt[k] != f_dep[k]);
                automatic bit ra = rd_en && (f_cnt[k] != 0);
                r_ack[k] <= wa;
                r_ovf[k] <= wr_en && (f_cnt[k] == f_dep[k]);
                r_udf[k] <= rd_en && (f_cnt[k] == 0);
                if (wa) begin
                    f_mem[k][f_wp[k]] <= data_in;
                    f_wp[k] <= (f_wp[k] + 1) % f_dep[k];
                end
                if (ra) begin
                    r_dout[k] <= f_mem[k][f_rp[k]] ^ ((k == 0 && corrupt) ? 16'h0100 : 16'h0000);
                    f_rp[k] <= (f_rp[k] + 1) % f_dep[k];
                end
                f_cnt[k] <= f_cnt[k] + int'(wa) - int'(ra);
            end
        end
    end

    logic        ep0, ep6, eps;
    logic [7:0]  ev0, ev6, evs, fe0, fe6, fes;
    logic [15:0] cc0, ec0, cc6, ec6;
    logic [2:0]  ccs, ecs;

    fifo_flag_checker #(.DATA_W(16), .DEPTH(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(r_dout[0]), .wr_ack(r_ack[0]), .overflow(r_ovf[0] & ~stub_ovf),
        .underflow(r_udf[0]), .full(f_cnt[0] == 8), .almostfull(f_cnt[0] == 7),
        .empty(f_cnt[0] == 0), .almostempty((f_cnt[0] == 1) & ~stub_ae),
        .err_pulse(ep0), .err_vec(ev0), .first_err(fe0), .correct_count(cc0), .error_count(ec0)
    );

    fifo_flag_checker #(.DATA_W(16), .DEPTH(6), .CNT_W(16)) u_dut6 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(r_dout[1]), .wr_ack(r_ack[1]), .overflow(r_ovf[1]),
        .underflow(r_udf[1]), .full(f_cnt[1] == 6), .almostfull(f_cnt[1] == 5),
        .empty(f_cnt[1] == 0), .almostempty(f_cnt[1] == 1),
        .err_pulse(ep6), .err_vec(ev6), .first_err(fe6), .correct_count(cc6), .error_count(ec6)
    );

    fifo_flag_checker #(.DATA_W(16), .DEPTH(8), .CNT_W(3)) u_dut_sat (
        .clk(clk), .rst(rst), .chk_en(chk_en), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(r_dout[0]), .wr_ack(r_ack[0]), .overflow(r_ovf[0]),
        .underflow(r_udf[0]), .full(f_cnt[0] == 8), .almostfull(f_cnt[0] == 7),
        .empty(f_cnt[0] == 0), .almostempty(f_cnt[0] == 1),
        .err_pulse(eps), .err_vec(evs), .first_err(fes), .correct_count(ccs), .error_count(ecs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_pulse"}, 32'(ep0), 0);
        check_eq({tag, "_errvec"}, 32'(ev0), 0);
        check_eq({tag, "_first"}, 32'(fe0), 0);
        check_eq({tag, "_correct"}, 32'(cc0), 0);
        check_eq({tag, "_errcnt"}, 32'(ec0), 0);
    endtask

    // Eight writes 1..8 then one idle edge; must follow a reset directly
    task automatic fill8();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; data_in = 16'(i);
            tick();
            check_eq("fill_correct", 32'(cc0), 32'(i));
            check_eq("fill_pulse", 32'(ep0), 0);
        end
        wr_en = 1'b0;
        tick();
        check_eq("fill_done_correct", 32'(cc0), 9);
        check_eq("fill_done_errcnt", 32'(ec0), 0);
    endtask

    initial begin
        rst = 1'b1; chk_en = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        stub_ovf = 1'b0; stub_ae = 1'b0; corrupt = 1'b0;

        do_reset();
        check_cleared("reset");
        fill8();
        check_eq("sat_correct", 32'(ccs), 7);
        check_eq("sat_errcnt", 32'(ecs), 0);
        check_eq("sat_errvec", 32'(evs), 0);
        check_eq("sat_first", 32'(fes), 0);
        check_eq("sat_pulse", 32'(eps), 0);

        // Overflow held low by a stubbed DUT
        stub_ovf = 1'b1; wr_en = 1'b1; data_in = 16'h0099;
        tick();
        check_eq("ovf_pulse_early", 32'(ep0), 0);
        check_eq("ovf_errcnt_early", 32'(ec0), 0);
        wr_en = 1'b0;
        tick();
        check_eq("ovf_pulse", 32'(ep0), 1);
        check_eq("ovf_errvec", 32'(ev0), 32'h04);
        check_eq("ovf_first", 32'(fe0), 32'h04);
        check_eq("ovf_errcnt", 32'(ec0), 1);
        check_eq("ovf_correct", 32'(cc0), 10);
        tick();
        check_eq("ovf_pulse_end", 32'(ep0), 0);
        check_eq("ovf_correct_end", 32'(cc0), 11);
        stub_ovf = 1'b0;

        // Read back in order, 3rd word corrupted
        do_reset();
        fill8();
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1; corrupt = (i == 3);
            tick();
            check_eq("rd_pulse", 32'(ep0), 32'(i == 4));
        end
        rd_en = 1'b0; corrupt = 1'b0;
        tick();
        check_eq("rd_errvec", 32'(ev0), 32'h01);
        check_eq("rd_first", 32'(fe0), 32'h01);
        check_eq("rd_errcnt", 32'(ec0), 1);
        check_eq("rd_correct", 32'(cc0), 17);

        // Empty: simultaneous read+write accepts only the write
        wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0055;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        check_eq("simul_correct", 32'(cc0), 19);
        check_eq("simul_errcnt", 32'(ec0), 1);
        stub_ae = 1'b1;
        tick();
        stub_ae = 1'b0;
        check_eq("ae_pulse", 32'(ep0), 1);
        check_eq("ae_errvec", 32'(ev0), 32'h81);
        check_eq("ae_first_hold", 32'(fe0), 32'h01);
        check_eq("ae_errcnt", 32'(ec0), 2);
        check_eq("ae_correct", 32'(cc0), 19);

        // Bring occupancy to 4, then reset mid-operation
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; data_in = 16'(16'h0061 + i);
            tick();
        end
        check_eq("pre_rst_correct", 32'(cc0), 22);
        rst = 1'b1; wr_en = 1'b0;
        tick();
        check_cleared("midrst");
        rst = 1'b0;
        tick();
        check_eq("post_rst_correct", 32'(cc0), 1);
        check_eq("post_rst_errcnt", 32'(ec0), 0);
        check_eq("post_rst_errvec", 32'(ev0), 0);

        // Checking disabled: model keeps tracking, counters freeze
        chk_en = 1'b0; wr_en = 1'b1; data_in = 16'h0077;
        tick();
        wr_en = 1'b0;
        tick();
        check_eq("chkoff_correct", 32'(cc0), 1);
        check_eq("chkoff_errcnt", 32'(ec0), 0);
        chk_en = 1'b1;
        tick();
        check_eq("chkon_correct", 32'(cc0), 2);
        check_eq("chkon_errcnt", 32'(ec0), 0);

        // DEPTH=6 pointer wrap: prefill 5, 20 simultaneous pairs, drain
        do_reset();
        check_eq("d6_reset_correct", 32'(cc6), 0);
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; data_in = 16'(16'h0100 + k);
            tick();
        end
        check_eq("d6_prefill_correct", 32'(cc6), 5);
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 16'(16'h0200 + k);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        tick();
        check_eq("d6_correct", 32'(cc6), 31);
        check_eq("d6_errcnt", 32'(ec6), 0);
        check_eq("d6_errvec", 32'(ev6), 0);
        check_eq("d6_first", 32'(fe6), 0);
        check_eq("d6_pulse", 32'(ep6), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
